// File: rtl/wb_pkg.sv
// Shared widths and the hold-buffer record for the GPR write-back path.
package wb_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int XLEN      = 64;
  localparam int STARVE_W  = 4;
  localparam int GPR_NUM   = 1 << GPR_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [GPR_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_hold_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-destination vector: one set port, one clear port and two read ports.
// Register 0 is never pending. When set and clear hit the same index in one
// cycle, the set wins.
module gpr_scoreboard
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [GPR_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [GPR_IDX_W-1:0] clr_idx,
  input  logic [GPR_IDX_W-1:0] rd_idx_a,
  input  logic [GPR_IDX_W-1:0] rd_idx_b,
  output logic                 rd_pend_a,
  output logic                 rd_pend_b,
  output logic [GPR_NUM-1:0]   pending_o
);

  logic [GPR_NUM-1:0] pending_q, pending_d;

  // Next pending vector: clear first so that a same-index set overrides it.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    if (set_en) pending_d[set_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending-vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rd_pend_a = pending_q[rd_idx_a];
  assign rd_pend_b = pending_q[rd_idx_b];
  assign pending_o = pending_q;

endmodule

// File: rtl/gpr_wb_arb.sv
// Shares the single GPR write port between the in-order LS stream and the
// out-of-band MDU result path. MDU results wait in a one-entry hold buffer;
// LS has priority until the held result has lost STARVE_MAX times in a row.
module gpr_wb_arb
  import wb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mdu_issue_valid,
  input  logic [GPR_IDX_W-1:0] mdu_issue_rd,
  input  logic [GPR_IDX_W-1:0] rs1,
  input  logic [GPR_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 ls_valid,
  output logic                 ls_ready,
  input  logic                 ls_trap,
  input  logic                 ls_wen,
  input  logic [GPR_IDX_W-1:0] ls_rd,
  input  logic [XLEN-1:0]      ls_data,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [GPR_IDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]      mdu_data,
  output logic                 gpr_wen,
  output logic [GPR_IDX_W-1:0] gpr_waddr,
  output logic [XLEN-1:0]      gpr_wdata
);

  wb_hold_t             hold_q, hold_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic                 ls_req;
  logic                 forced;
  logic                 hold_drain;
  logic                 mdu_load;
  logic                 pend_a, pend_b;
  logic [GPR_NUM-1:0]   pending;

  // Arbitration: a non-writing LS op still takes the slot but leaves the port
  // free, so the held result drains whenever it is not contending.
  always_comb begin
    ls_req     = ls_valid && ls_wen && !ls_trap && (ls_rd != '0);
    forced     = hold_q.valid && (starve_cnt_q == STARVE_W'(STARVE_MAX));
    hold_drain = hold_q.valid && (!ls_req || forced);
    ls_ready   = !forced;
    mdu_ready  = !hold_q.valid;
    mdu_load   = mdu_valid && !hold_q.valid;
  end

  // Write port driven by the winner; a held rd==0 result drains silently.
  always_comb begin
    gpr_wen   = 1'b0;
    gpr_waddr = '0;
    gpr_wdata = '0;
    if (hold_drain) begin
      gpr_wen   = (hold_q.rd != '0);
      gpr_waddr = hold_q.rd;
      gpr_wdata = hold_q.data;
    end else if (ls_req) begin
      gpr_wen   = 1'b1;
      gpr_waddr = ls_rd;
      gpr_wdata = ls_data;
    end
  end

  // Next hold entry and consecutive-loss count.
  always_comb begin
    hold_d = hold_q;
    if (hold_drain) hold_d.valid = 1'b0;
    if (mdu_load) begin
      hold_d.valid = 1'b1;
      hold_d.rd    = mdu_rd;
      hold_d.data  = mdu_data;
    end
    if (!hold_q.valid || hold_drain) starve_cnt_d = '0;
    else                             starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Hold buffer and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      hold_q       <= hold_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  gpr_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (mdu_issue_valid),
    .set_idx   (mdu_issue_rd),
    .clr_en    (hold_drain),
    .clr_idx   (hold_q.rd),
    .rd_idx_a  (rs1),
    .rd_idx_b  (rs2),
    .rd_pend_a (pend_a),
    .rd_pend_b (pend_b),
    .pending_o (pending)
  );

  // A held result is already pending, but also flag it explicitly.
  always_comb begin
    rs1_busy = pend_a | (hold_q.valid && (hold_q.rd == rs1) && (rs1 != '0));
    rs2_busy = pend_b | (hold_q.valid && (hold_q.rd == rs2) && (rs2 != '0));
  end

  // IDU must never let LS write a register still owed an MDU result.
  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n)
                             !(ls_req && pending[ls_rd]));

endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;

  localparam int SM = 4;

  typedef struct {
    bit        iv;
    bit [4:0]  ird;
    bit        lv, lw, lt;
    bit [4:0]  lrd;
    bit [63:0] ld;
    bit        mv;
    bit [4:0]  mrd;
    bit [63:0] md;
    bit [4:0]  r1, r2;
  } stim_t;

  typedef struct {
    bit        wen;
    bit [4:0]  addr;
    bit [63:0] data;
    bit        lrdy, mrdy, b1, b2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  stim_t st, nxt;

  logic        rs1_busy, rs2_busy, ls_ready, mdu_ready, gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [63:0] gpr_wdata;

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  bit [4:0] outst[$];

  // reference model state: held result, consecutive losses, pending set
  bit        m_hv;
  bit [4:0]  m_hrd;
  bit [63:0] m_hd;
  int        m_loss;
  bit        m_pend[32];

  always #5 clk = ~clk;

  gpr_wb_arb #(.STARVE_MAX(SM)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mdu_issue_valid (st.iv),
    .mdu_issue_rd    (st.ird),
    .rs1             (st.r1),
    .rs2             (st.r2),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .ls_valid        (st.lv),
    .ls_ready        (ls_ready),
    .ls_trap         (st.lt),
    .ls_wen          (st.lw),
    .ls_rd           (st.lrd),
    .ls_data         (st.ld),
    .mdu_valid       (st.mv),
    .mdu_ready       (mdu_ready),
    .mdu_rd          (st.mrd),
    .mdu_data        (st.md),
    .gpr_wen         (gpr_wen),
    .gpr_waddr       (gpr_waddr),
    .gpr_wdata       (gpr_wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hv = 0; m_hrd = 0; m_hd = 0; m_loss = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  task automatic idle();
    nxt = '{default: 0};
  endtask

  // Apply one cycle of stimulus, predict the outputs, advance the model.
  task automatic step();
    exp_t e;
    bit mrdy, forced, lreq, hw;
    @(posedge clk);
    #1;
    st = nxt;
    mrdy   = !m_hv;
    forced = m_hv && (m_loss == SM);
    lreq   = st.lv && st.lw && !st.lt && (st.lrd != 0);
    hw     = m_hv && (!lreq || forced);
    e = '{default: 0};
    e.lrdy = !forced;
    e.mrdy = mrdy;
    if (hw) begin
      e.wen = (m_hrd != 0); e.addr = m_hrd; e.data = m_hd;
    end else if (lreq) begin
      e.wen = 1; e.addr = st.lrd; e.data = st.ld;
    end
    e.b1 = m_pend[st.r1] || (m_hv && m_hrd == st.r1 && st.r1 != 0);
    e.b2 = m_pend[st.r2] || (m_hv && m_hrd == st.r2 && st.r2 != 0);
    exp_q.push_back(e);
    if (hw) m_pend[m_hrd] = 0;
    if (st.iv) m_pend[st.ird] = 1;
    m_pend[0] = 0;
    if (hw || !m_hv) m_loss = 0;
    else m_loss++;
    if (hw) m_hv = 0;
    if (st.mv && mrdy) begin
      m_hv = 1; m_hrd = st.mrd; m_hd = st.md;
    end
  endtask

  task automatic ls_write3();
    nxt.lv = 1; nxt.lw = 1; nxt.lrd = 5'd3; nxt.ld = 64'h3333;
  endtask

  // Monitor: pop the prediction for this cycle and compare every output.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("gpr_wen", 64'(gpr_wen), 64'(mon_e.wen));
      if (mon_e.wen) begin
        chk("gpr_waddr", 64'(gpr_waddr), 64'(mon_e.addr));
        chk("gpr_wdata", gpr_wdata, mon_e.data);
      end
      chk("ls_ready", 64'(ls_ready), 64'(mon_e.lrdy));
      chk("mdu_ready", 64'(mdu_ready), 64'(mon_e.mrdy));
      chk("rs1_busy", 64'(rs1_busy), 64'(mon_e.b1));
      chk("rs2_busy", 64'(rs2_busy), 64'(mon_e.b2));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st = '{default: 0};
    model_reset();
    #12;
    chk("rst_gpr_wen", 64'(gpr_wen), 0);
    chk("rst_mdu_ready", 64'(mdu_ready), 1);
    chk("rst_ls_ready", 64'(ls_ready), 1);
    chk("rst_rs1_busy", 64'(rs1_busy), 0);
    chk("rst_rs2_busy", 64'(rs2_busy), 0);
    @(negedge clk) rst_n = 1;

    // LS write lands in the same cycle
    idle(); nxt.lv = 1; nxt.lw = 1; nxt.lrd = 5'd5; nxt.ld = 64'hAA; step();
    @(negedge clk); #1;
    chk("t1_wen", 64'(gpr_wen), 1);
    chk("t1_waddr", 64'(gpr_waddr), 5);
    chk("t1_wdata", gpr_wdata, 64'hAA);
    chk("t1_mdu_ready", 64'(mdu_ready), 1);

    // MDU rd=7: written at N+1, busy through N+1, free at N+2
    idle(); nxt.iv = 1; nxt.ird = 5'd7; step();
    idle(); nxt.mv = 1; nxt.mrd = 5'd7; nxt.md = 64'h1234; nxt.r1 = 5'd7; step();
    idle(); nxt.r1 = 5'd7; step();
    @(negedge clk); #1;
    chk("t2_wen", 64'(gpr_wen), 1);
    chk("t2_waddr", 64'(gpr_waddr), 7);
    chk("t2_wdata", gpr_wdata, 64'h1234);
    chk("t2_busy_n1", 64'(rs1_busy), 1);
    idle(); nxt.r1 = 5'd7; step();
    @(negedge clk); #1;
    chk("t2_busy_n2", 64'(rs1_busy), 0);

    // starvation: LS wins SM cycles, then the held result is forced through
    idle(); ls_write3(); nxt.iv = 1; nxt.ird = 5'd11; step();
    idle(); ls_write3(); nxt.mv = 1; nxt.mrd = 5'd11; nxt.md = 64'h5555; step();
    for (int i = 0; i < SM; i++) begin
      idle(); ls_write3(); step();
      @(negedge clk); #1;
      chk("t3_ls_wins_ready", 64'(ls_ready), 1);
      chk("t3_ls_wins_addr", 64'(gpr_waddr), 3);
    end
    idle(); ls_write3(); step();
    @(negedge clk); #1;
    chk("t3_forced_ready", 64'(ls_ready), 0);
    chk("t3_forced_addr", 64'(gpr_waddr), 11);
    chk("t3_forced_data", gpr_wdata, 64'h5555);
    idle(); ls_write3(); step();
    @(negedge clk); #1;
    chk("t3_after_ready", 64'(ls_ready), 1);
    chk("t3_after_addr", 64'(gpr_waddr), 3);

    // non-writing LS op (wen=0, then trap) lets the held result through
    idle(); ls_write3(); nxt.iv = 1; nxt.ird = 5'd12; step();
    idle(); ls_write3(); nxt.mv = 1; nxt.mrd = 5'd12; nxt.md = 64'h77; step();
    idle(); nxt.lv = 1; nxt.lrd = 5'd3; step();
    @(negedge clk); #1;
    chk("t4_nowen_addr", 64'(gpr_waddr), 12);
    chk("t4_nowen_ready", 64'(ls_ready), 1);
    idle(); ls_write3(); nxt.iv = 1; nxt.ird = 5'd14; step();
    idle(); ls_write3(); nxt.mv = 1; nxt.mrd = 5'd14; nxt.md = 64'h88; step();
    idle(); ls_write3(); nxt.lt = 1; step();
    @(negedge clk); #1;
    chk("t4_trap_addr", 64'(gpr_waddr), 14);

    // same-index set during drain wins; different indices both apply
    idle(); nxt.iv = 1; nxt.ird = 5'd9; step();
    idle(); nxt.mv = 1; nxt.mrd = 5'd9; nxt.md = 64'h99; step();
    idle(); nxt.iv = 1; nxt.ird = 5'd9; step();
    idle(); nxt.r1 = 5'd9; nxt.mv = 1; nxt.mrd = 5'd9; nxt.md = 64'h999; step();
    @(negedge clk); #1;
    chk("t5_same_idx_busy", 64'(rs1_busy), 1);
    idle(); nxt.iv = 1; nxt.ird = 5'd4; step();
    idle(); nxt.r1 = 5'd4; nxt.r2 = 5'd9; step();
    @(negedge clk); #1;
    chk("t5_set4_busy", 64'(rs1_busy), 1);
    chk("t5_clr9_busy", 64'(rs2_busy), 0);
    idle(); nxt.mv = 1; nxt.mrd = 5'd4; nxt.md = 64'h4; step();
    idle(); step();

    // rd=0 result drains without a write
    idle(); nxt.mv = 1; nxt.mrd = 5'd0; nxt.md = 64'hFF; step();
    idle(); step();
    @(negedge clk); #1;
    chk("t6_rd0_wen", 64'(gpr_wen), 0);
    chk("t6_rd0_mdu_ready", 64'(mdu_ready), 0);
    idle(); step();
    @(negedge clk); #1;
    chk("t6_rd0_ready_back", 64'(mdu_ready), 1);

    // asynchronous reset while a result is held
    idle(); ls_write3(); nxt.iv = 1; nxt.ird = 5'd13; step();
    idle(); ls_write3(); nxt.mv = 1; nxt.mrd = 5'd13; nxt.md = 64'hD; step();
    idle(); ls_write3(); nxt.r1 = 5'd13; step();
    @(negedge clk); #1;
    chk("t7_pre_mdu_ready", 64'(mdu_ready), 0);
    st.lv = 0;
    rst_n = 0;
    exp_q.delete();
    #1;
    chk("t7_rst_gpr_wen", 64'(gpr_wen), 0);
    chk("t7_rst_mdu_ready", 64'(mdu_ready), 1);
    chk("t7_rst_rs1_busy", 64'(rs1_busy), 0);
    chk("t7_rst_ls_ready", 64'(ls_ready), 1);
    model_reset();
    outst.delete();
    st = '{default: 0};
    @(negedge clk) rst_n = 1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      if (!m_hv && outst.size() > 0 && ($urandom % 3 == 0)) begin
        nxt.mv = 1; nxt.mrd = outst.pop_front(); nxt.md = {$urandom, $urandom};
      end
      if (outst.size() < 4 && ($urandom % 4 == 0)) begin
        bit [4:0] r;
        r = 5'($urandom % 32);
        if (r == 0 || !m_pend[r]) begin
          bit dup;
          dup = 0;
          foreach (outst[k]) if (outst[k] == r && r != 0) dup = 1;
          if (!dup) begin
            nxt.iv = 1; nxt.ird = r; outst.push_back(r);
          end
        end
      end
      nxt.lv  = ($urandom % 4 != 0);
      nxt.lw  = ($urandom % 4 != 0);
      nxt.lt  = ($urandom % 8 == 0);
      nxt.lrd = 5'($urandom % 32);
      nxt.ld  = {$urandom, $urandom};
      if (m_pend[nxt.lrd]) nxt.lw = 0;
      nxt.r1 = 5'($urandom % 32);
      nxt.r2 = 5'($urandom % 32);
      step();
    end
    idle(); step();
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arb.md
# gpr_wb_arb

Write-port arbiter and scoreboard for the single general-register write port. It shares that port between the in-order LS→WB retirement stream and the out-of-band multi-cycle divide/multiply unit (MDU), which returns results after the issuing instruction has left EXU. A 32-entry pending-destination scoreboard tells IDU/EXU which registers still await an MDU result.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive cycles a held MDU result may lose arbitration before it is forced through; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mdu_issue_valid  in  1  MDU accepted an op whose result targets mdu_issue_rd
- mdu_issue_rd  in  5  destination of the issued MDU op
- rs1  in  5  IDU source index 1
- rs2  in  5  IDU source index 2
- rs1_busy  out  1  rs1 awaits an MDU result
- rs2_busy  out  1  rs2 awaits an MDU result
- ls_valid  in  1  LS→WB instruction present
- ls_ready  out  1  WB accepts the LS instruction this cycle
- ls_trap  in  1  instruction traps; no register write
- ls_wen  in  1  instruction writes rd
- ls_rd  in  5  LS destination
- ls_data  in  64  LS write data, already muxed with CSR read data
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  hold buffer empty; result accepted
- mdu_rd  in  5  MDU result destination
- mdu_data  in  64  MDU result
- gpr_wen  out  1  register file write enable
- gpr_waddr  out  5  register file write index
- gpr_wdata  out  64  register file write data

## Operation
- Hold buffer: one entry of {valid, rd, data}.
  - Loads on mdu_valid && mdu_ready.
  - mdu_ready = !hold_valid; this is a registered-state output, not a pass-through.
- LS write request: ls_req = ls_valid && ls_wen && !ls_trap && ls_rd != 0.
- Arbitration each cycle:
  - If hold_valid and starve_cnt == STARVE_MAX: hold wins and ls_ready = 0.
  - Otherwise LS wins and ls_ready = 1. A non-writing LS instruction (no ls_req) still consumes the grant slot, so hold writes in the same cycle it is not contending.
  - Concretely, hold writes when hold_valid && (!ls_req || forced).
- Write port (combinational from the winner):
  - gpr_wen is high only for a winning write with rd != 0.
  - A hold entry with rd == 0 drains without asserting gpr_wen.
- Starvation counter (4-bit):
  - Resets to 0.
  - Increments when hold_valid and hold loses.
  - Clears when hold drains or hold is empty.
- Scoreboard: 32-bit pending vector, bit 0 hard-wired to 0.
  - Set: mdu_issue_valid sets bit mdu_issue_rd.
  - Clear: the hold-buffer drain clears bit hold_rd.
  - Same cycle, same index: set wins.
  - Different indices: both apply.
- Busy outputs: rs1_busy = pending[rs1] | (hold_valid && hold_rd == rs1 && rs1 != 0); rs2_busy likewise.
- Upstream contract:
  - IDU stalls any op whose rd or rs is busy, so LS never writes an rd with a pending MDU result (no WAW).
  - Checked by assertion: ls_req && pending[ls_rd] is illegal.

## Timing
- Reset values: gpr_wen 0, mdu_ready 1, rs1_busy/rs2_busy 0, hold_valid 0, starve_cnt 0, pending 0.
- ls_ready is 1 out of reset (combinational).
- LS write: zero-latency, in the acceptance cycle.
- MDU result latency:
  - Captured at edge N.
  - Earliest write in cycle N+1.
  - Worst case write in cycle N+1+STARVE_MAX.
- New MDU result: accepted the cycle after the drain, because mdu_ready follows hold_valid.
- Scoreboard:
  - A set is visible on rs*_busy the cycle after issue.
  - A clear is visible the cycle after the drain write.
- Reset mid-operation: the buffered result and pending bits are discarded. The core restarts from RST_PC, so no recovery is required.

## Structure
- Shared package `wb_pkg`:
  - GPR_IDX_W = 5
  - XLEN = 64
  - STARVE_W = 4
  - a `wb_hold_t` struct {valid, rd, data}
- Sub-module `gpr_scoreboard`:
  - 32-bit set/clear vector with two read ports.
  - Reused by a future FPU.
- Arbitration, hold buffer and starvation counter stay in the top module.

## Test plan
- Reset, then LS stream rd=5 data=0xAA → gpr_wen=1, waddr=5, wdata=0xAA in the same cycle; mdu_ready=1.
- Issue MDU rd=7, LS idle, MDU returns 0x1234 at edge N → cycle N+1: gpr_wen=1, waddr=7; rs1=7 is busy through cycle N+1 and not busy at N+2.
- MDU result held while LS writes rd=3 every cycle, STARVE_MAX=4 → LS wins 4 cycles; 5th cycle ls_ready=0 and the MDU result is written; the next cycle ls_ready=1.
- Held MDU result plus LS instruction with ls_wen=0 (or ls_trap=1) → MDU result written that cycle; starve_cnt stays 0.
- Drain rd=9 while issuing a new MDU op rd=9 in the same cycle → pending[9] remains 1; issue rd=4 while draining rd=9 → pending[4]=1, pending[9]=0.
- MDU result with rd=0 → no gpr_wen; buffer drains; mdu_ready returns to 1. Assert rst_n low while hold_valid=1 → all outputs go to reset values immediately.
